// File: rtl/cacheline_burst_adapter_if.sv
// Bundle of arbiter-side line signals and memory-side burst signals.
// The adapter connects through the slave modport; the environment driving
// the arbiter and memory sides uses the master modport.
interface cacheline_burst_adapter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
);
  // Arbiter side
  logic [31:0]           line_address;
  logic                  line_read;
  logic                  line_write;
  logic [LINE_WIDTH-1:0] line_wdata;
  logic [LINE_WIDTH-1:0] line_rdata;
  logic                  line_resp;
  // Memory side
  logic [31:0]           mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [BEAT_WIDTH-1:0] mem_wdata;
  logic [BEAT_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;
  // Current FSM state, exported for observation
  logic [2:0]            dbg_state;

  modport slave (
    input  line_address, line_read, line_write, line_wdata,
    output line_rdata, line_resp,
    output mem_address, mem_read, mem_write, mem_wdata,
    input  mem_rdata, mem_resp,
    output dbg_state
  );

  modport master (
    output line_address, line_read, line_write, line_wdata,
    input  line_rdata, line_resp,
    input  mem_address, mem_read, mem_write, mem_wdata,
    output mem_rdata, mem_resp,
    input  dbg_state
  );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Cacheline burst adapter: turns one line read/write from the arbiter into a
// BEATS-long burst on the memory port and returns a one-cycle line_resp.
//
// Handshake: line_read/line_write are levels held by the arbiter until
// line_resp; they are sampled only in IDLE. On the memory side mem_read or
// mem_write stays high for the whole burst and every cycle with mem_resp=1
// transfers exactly one beat (beat 0 = line bits [BEAT_WIDTH-1:0] first).
module cacheline_burst_adapter #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = LINE_WIDTH / BEAT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  cacheline_burst_adapter_if.slave        bus
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_BURST = 3'd1,
    RD_DONE  = 3'd2,
    WR_BURST = 3'd3,
    WR_DONE  = 3'd4
  } state_t;

  state_t                                state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [31:0]                           addr_q, addr_d;
  // Line buffer shared by reads (assembly) and writes (serialisation)
  logic [BEATS-1:0][BEAT_WIDTH-1:0]      buf_q, buf_d;

  logic                                  line_resp;
  logic                                  mem_read;
  logic                                  mem_write;
  logic [31:0]                           mem_address;
  logic [BEAT_WIDTH-1:0]                 mem_wdata;

  // State, counter, address and line buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic and Moore outputs; outputs are zero outside the bursts
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    buf_d       = buf_q;
    line_resp   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        // Read has priority when both requests are present
        if (bus.line_read) begin
          addr_d  = {bus.line_address[31:OFF_W], {OFF_W{1'b0}}};
          cnt_d   = '0;
          state_d = RD_BURST;
        end else if (bus.line_write) begin
          addr_d  = {bus.line_address[31:OFF_W], {OFF_W{1'b0}}};
          buf_d   = bus.line_wdata;
          cnt_d   = '0;
          state_d = WR_BURST;
        end
      end

      RD_BURST: begin
        mem_read    = 1'b1;
        mem_address = addr_q;
        if (bus.mem_resp) begin
          buf_d[cnt_q] = bus.mem_rdata;
          if (cnt_q == LAST_BEAT) begin
            state_d = RD_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      RD_DONE: begin
        line_resp = 1'b1;
        state_d   = IDLE;
      end

      WR_BURST: begin
        mem_write   = 1'b1;
        mem_address = addr_q;
        mem_wdata   = buf_q[cnt_q];
        if (bus.mem_resp) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = WR_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      WR_DONE: begin
        line_resp = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.line_rdata  = buf_q;
  assign bus.line_resp   = line_resp;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.mem_address = mem_address;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.dbg_state   = state_q;

endmodule

// File: doc/cacheline_burst_adapter.md
Name: cacheline_burst_adapter

Overview:
- Sits directly downstream of the memory arbiter.
- Converts one 256-bit cacheline read or write request into a 4-beat, 64-bit burst transaction on the physical memory port.
- Assembles read beats into a full line and returns a single-cycle line response to the arbiter.
- Serialises write lines into beats.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits.
- BEAT_WIDTH, 64, memory data bus width in bits.
- BEATS, LINE_WIDTH/BEAT_WIDTH (4), beats per burst. Derived; not overridden independently.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- line_address  input  32  line request address from arbiter.
- line_read  input  1  line read request, held until line_resp.
- line_write  input  1  line write request, held until line_resp.
- line_wdata  input  256  write line data.
- line_rdata  output  256  assembled read line.
- line_resp  output  1  one-cycle completion pulse to arbiter.
- mem_address  output  32  burst base address to memory.
- mem_read  output  1  burst read request.
- mem_write  output  1  burst write request.
- mem_wdata  output  64  current write beat.
- mem_rdata  input  64  current read beat.
- mem_resp  input  1  beat strobe from memory; one beat transferred per cycle high.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, beat counter=0, line buffer=0. All outputs are 0: line_rdata, line_resp, mem_address, mem_read, mem_write, mem_wdata.
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE:
  - line_read=1: latch {line_address[31:5],5'b0} into the address register, counter=0, go to RD_BURST.
  - Else line_write=1: latch the aligned address and line_wdata into the buffer, counter=0, go to WR_BURST.
  - line_read and line_write both high: read wins; the write is ignored for this transaction.
  - mem_resp in IDLE is ignored.
- RD_BURST:
  - mem_read=1, mem_address=latched address.
  - Each cycle with mem_resp=1: buffer[counter*64 +: 64] <= mem_rdata, counter++.
  - Cycles with mem_resp=0 (gaps) hold state and counter.
  - On the cycle the beat at counter=BEATS-1 is accepted: go to RD_DONE.
- RD_DONE:
  - line_resp=1 for exactly one cycle, mem_read=0, go to IDLE.
  - line_rdata is driven from the buffer at all times. It is valid from RD_DONE until the first beat of the next read overwrites it.
- WR_BURST:
  - mem_write=1, mem_address=latched address, mem_wdata=buffer[counter*64 +: 64].
  - Each mem_resp=1 cycle consumes the current beat, counter++.
  - Last beat (counter=BEATS-1) accepted: go to WR_DONE.
- WR_DONE: line_resp=1 for one cycle, mem_write=0, go to IDLE.
- Latency, zero-gap memory: line_resp is asserted 1 cycle after the 4th mem_resp cycle. The request is visible on mem_* the cycle after line_read/line_write is sampled in IDLE.
- Counter: 2 bits, wraps to 0 only via the IDLE entry. No wrap inside a burst.
- line_address low 5 bits are ignored. Beat 0 is always line bits [63:0].
- Changes to line_wdata or line_address mid-burst have no effect, because they are latched at start.
- The arbiter drops its request the cycle after line_resp. The adapter is already in IDLE then, so no duplicate transaction occurs.
- Reset mid-burst: transaction abandoned immediately. Outputs go to 0 asynchronously, and no line_resp is issued.
- Extra mem_resp in RD_DONE or WR_DONE is ignored.

Test Plan:
- Reset, then line_read with address 0x0000_1234. Memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive cycles.
  - Required: mem_address=0x0000_1220 and mem_read=1.
  - Required: line_resp pulses once, the cycle after beat 4.
  - Required: line_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- line_write with line_wdata = {D3,D2,D1,D0}, and mem_resp high with 1-cycle gaps between beats.
  - Required: mem_wdata steps D0→D1→D2→D3, advancing only after resp cycles.
  - Required: mem_write drops in WR_DONE, with a single line_resp.
- line_read and line_write asserted together.
  - Required: only mem_read asserts; mem_write stays 0 for the whole transaction.
- Assert rst after 2 read beats.
  - Required: mem_read=0 and line_rdata=0 immediately, with no line_resp.
  - Required: a following read completes normally with correct data.
- Back-to-back transactions: read, then write re-issued the cycle after line_resp.
  - Required: exactly one line_resp per request, and no spurious memory request between them.
- mem_resp pulsed while in IDLE with no request.
  - Required: state stays IDLE and all outputs stay 0.
